csr_access_unit: RTL and testbench

- Upstream sequencer for the core's CSR bus. Takes one decoded Zicsr instruction at a time (CSRRW/RS/RC and immediate forms) and performs its read-modify-write as bus transactions.
- Drives the shared csrRead*/csrWrite* signals that fan out to every CSR register slice. Consumes the OR-reduced csrReadData/csrRequestOutput returned by those slices.
- Returns the rd result, or an illegal-instruction flag, to the pipeline.

---
 rtl/csr_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_csr_access_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_unit
// Purpose  : Sequences one decoded Zicsr instruction (CSRRW/RS/RC and their
//            immediate forms) as a read-modify-write on the shared CSR bus,
//            then returns the old CSR value or an illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
module csr_access_unit (
  input  logic        clk,
  input  logic        rst,              // asynchronous, active-low
  input  logic        instrValid,
  input  logic [2:0]  csrOp,
  input  logic [11:0] csrAddress,
  input  logic [31:0] rs1Data,
  input  logic [4:0]  rs1Index,
  input  logic [4:0]  rdIndex,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] rdData,
  output logic        rdWriteEnable,
  output logic        csrReadEnable,
  output logic [11:0] csrReadAddress,
  output logic        csrWriteEnable,
  output logic [11:0] csrWriteAddress,
  output logic [31:0] csrWriteData,
  input  logic [31:0] csrReadData,
  input  logic        csrRequestOutput
);

  // funct3[1:0] selects the operation; funct3[2] selects the immediate form
  localparam logic [1:0] c_FUNC_BAD = 2'b00;
  localparam logic [1:0] c_FUNC_RW  = 2'b01;
  localparam logic [1:0] c_FUNC_RS  = 2'b10;
  localparam logic [1:0] c_FUNC_RC  = 2'b11;

  // Address bits [11:10] == 2'b11 mark the read-only CSR space
  localparam logic [1:0] c_RO_SPACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_opFunc;
  logic [11:0] r_address;
  logic [4:0]  r_rdIndex;
  logic [31:0] r_src;
  logic        r_suppress;
  logic [31:0] r_oldValue;

  logic [31:0] w_src;
  logic        w_suppress;
  logic        w_opIllegal;
  logic        w_directWrite;
  logic        w_readOnly;
  logic        w_rdNonZero;
  logic [31:0] w_newValue;

  // Decode of the incoming instruction, only consumed while in IDLE
  always_comb begin
    w_src         = csrOp[2] ? {27'b0, rs1Index} : rs1Data;
    // RS/RC forms with rs1/zimm == 0 must not write (no write side effects)
    w_suppress    = csrOp[1] && (rs1Index == 5'd0);
    w_opIllegal   = (csrOp[1:0] == c_FUNC_BAD);
    // RW with rd == 0 skips the read entirely so read side effects never occur
    w_directWrite = (csrOp[1:0] == c_FUNC_RW) && (rdIndex == 5'd0);
  end

  // Modify step: combine the value returned in READ with the latched source
  always_comb begin
    w_newValue  = r_src;
    w_readOnly  = (r_address[11:10] == c_RO_SPACE);
    w_rdNonZero = (r_rdIndex != 5'd0);
    case (r_opFunc)
      c_FUNC_RW: w_newValue = r_src;
      c_FUNC_RS: w_newValue = csrReadData | r_src;
      c_FUNC_RC: w_newValue = csrReadData & ~r_src;
      default:   w_newValue = r_src;
    endcase
  end

  // Sequencer: state, latched operands and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_opFunc        <= 2'b00;
      r_address       <= 12'd0;
      r_rdIndex       <= 5'd0;
      r_src           <= 32'd0;
      r_suppress      <= 1'b0;
      r_oldValue      <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      illegal         <= 1'b0;
      rdData          <= 32'd0;
      rdWriteEnable   <= 1'b0;
      csrReadEnable   <= 1'b0;
      csrReadAddress  <= 12'd0;
      csrWriteEnable  <= 1'b0;
      csrWriteAddress <= 12'd0;
      csrWriteData    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instrValid) begin
            r_opFunc   <= csrOp[1:0];
            r_address  <= csrAddress;
            r_rdIndex  <= rdIndex;
            r_src      <= w_src;
            r_suppress <= w_suppress;
            // Reported old value is zero unless a read actually happens
            r_oldValue <= 32'd0;
            busy       <= 1'b1;
            if (w_opIllegal) begin
              r_state       <= DONE;
              done          <= 1'b1;
              illegal       <= 1'b1;
              rdData        <= 32'd0;
              rdWriteEnable <= 1'b0;
            end else if (w_directWrite) begin
              r_state         <= WRITE;
              csrWriteEnable  <= 1'b1;
              csrWriteAddress <= csrAddress;
              csrWriteData    <= w_src;
            end else begin
              r_state        <= READ;
              csrReadEnable  <= 1'b1;
              csrReadAddress <= csrAddress;
            end
          end
        end

        READ: begin
          csrReadEnable <= 1'b0;
          r_oldValue    <= csrReadData;
          if (!csrRequestOutput) begin
            // No slice claimed the address: unmapped CSR
            r_state       <= DONE;
            done          <= 1'b1;
            illegal       <= 1'b1;
            rdData        <= csrReadData;
            rdWriteEnable <= 1'b0;
          end else if (r_suppress) begin
            // Pure read: finish without touching the CSR
            r_state       <= DONE;
            done          <= 1'b1;
            illegal       <= 1'b0;
            rdData        <= csrReadData;
            rdWriteEnable <= w_rdNonZero;
          end else if (w_readOnly) begin
            // Write attempted into read-only space
            r_state       <= DONE;
            done          <= 1'b1;
            illegal       <= 1'b1;
            rdData        <= csrReadData;
            rdWriteEnable <= 1'b0;
          end else begin
            r_state         <= WRITE;
            csrWriteEnable  <= 1'b1;
            csrWriteAddress <= r_address;
            csrWriteData    <= w_newValue;
          end
        end

        WRITE: begin
          csrWriteEnable <= 1'b0;
          r_state        <= DONE;
          done           <= 1'b1;
          illegal        <= 1'b0;
          rdData         <= r_oldValue;
          rdWriteEnable  <= w_rdNonZero;
        end

        DONE: begin
          // Completion flags last exactly one cycle; rdData simply holds
          r_state       <= IDLE;
          done          <= 1'b0;
          illegal       <= 1'b0;
          rdWriteEnable <= 1'b0;
          busy          <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_access_unit
// Purpose  : Directed self-checking bench for csr_access_unit. Inputs are
//            driven 1 time unit after the rising edge; outputs are checked at
//            the same point, well away from the next active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;

  logic        clk;
  logic        rst;
  logic        instrValid;
  logic [2:0]  csrOp;
  logic [11:0] csrAddress;
  logic [31:0] rs1Data;
  logic [4:0]  rs1Index;
  logic [4:0]  rdIndex;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [31:0] rdData;
  logic        rdWriteEnable;
  logic        csrReadEnable;
  logic [11:0] csrReadAddress;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;

  int testsRun;
  int testsFailed;

  csr_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .instrValid       (instrValid),
    .csrOp            (csrOp),
    .csrAddress       (csrAddress),
    .rs1Data          (rs1Data),
    .rs1Index         (rs1Index),
    .rdIndex          (rdIndex),
    .busy             (busy),
    .done             (done),
    .illegal          (illegal),
    .rdData           (rdData),
    .rdWriteEnable    (rdWriteEnable),
    .csrReadEnable    (csrReadEnable),
    .csrReadAddress   (csrReadAddress),
    .csrWriteEnable   (csrWriteEnable),
    .csrWriteAddress  (csrWriteAddress),
    .csrWriteData     (csrWriteData),
    .csrReadData      (csrReadData),
    .csrRequestOutput (csrRequestOutput)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction plus the slice response it will see
  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] r1d,
                       input logic [4:0] r1i, input logic [4:0] rd,
                       input logic [31:0] rdat, input logic hit);
    csrOp            = op;
    csrAddress       = addr;
    rs1Data          = r1d;
    rs1Index         = r1i;
    rdIndex          = rd;
    csrReadData      = rdat;
    csrRequestOutput = hit;
    instrValid       = 1'b1;
  endtask

  initial begin
    testsRun         = 0;
    testsFailed      = 0;
    rst              = 1'b0;
    instrValid       = 1'b0;
    csrOp            = 3'b000;
    csrAddress       = 12'h000;
    rs1Data          = 32'h0;
    rs1Index         = 5'd0;
    rdIndex          = 5'd0;
    csrReadData      = 32'h0;
    csrRequestOutput = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_rdData", rdData, 0);
    chk("rst_rdWe", rdWriteEnable, 0);
    chk("rst_re", csrReadEnable, 0);
    chk("rst_we", csrWriteEnable, 0);
    chk("rst_raddr", csrReadAddress, 0);
    chk("rst_waddr", csrWriteAddress, 0);
    chk("rst_wdata", csrWriteData, 0);
    rst = 1'b1;
    tick();

    // ---------------- CSRRW 0x340 full RMW ----------------
    issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd7, 5'd5, 32'h12345678, 1'b1);
    tick();
    instrValid = 1'b0;
    chk("rw_read_re", csrReadEnable, 1);
    chk("rw_read_addr", csrReadAddress, 32'h340);
    chk("rw_read_we", csrWriteEnable, 0);
    chk("rw_read_busy", busy, 1);
    tick();
    chk("rw_write_we", csrWriteEnable, 1);
    chk("rw_write_re", csrReadEnable, 0);
    chk("rw_write_addr", csrWriteAddress, 32'h340);
    chk("rw_write_data", csrWriteData, 32'hDEADBEEF);
    tick();
    chk("rw_done", done, 1);
    chk("rw_we_off", csrWriteEnable, 0);
    chk("rw_rdData", rdData, 32'h12345678);
    chk("rw_rdWe", rdWriteEnable, 1);
    chk("rw_illegal", illegal, 0);
    tick();
    chk("rw_done_pulse", done, 0);
    chk("rw_idle_busy", busy, 0);

    // ---------------- CSRRS rs1=0: read only ----------------
    issue(3'b010, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd3, 32'h00000088, 1'b1);
    tick();
    instrValid = 1'b0;
    chk("rs0_read_re", csrReadEnable, 1);
    chk("rs0_read_addr", csrReadAddress, 32'h300);
    tick();
    chk("rs0_done", done, 1);
    chk("rs0_no_we", csrWriteEnable, 0);
    chk("rs0_rdData", rdData, 32'h88);
    chk("rs0_rdWe", rdWriteEnable, 1);
    tick();

    // ---------------- CSRRCI zimm=8 on 0x88 ----------------
    issue(3'b111, 12'h300, 32'hFFFFFFFF, 5'd8, 5'd1, 32'h00000088, 1'b1);
    tick();
    instrValid = 1'b0;
    tick();
    chk("rci_we", csrWriteEnable, 1);
    chk("rci_wdata", csrWriteData, 32'h80);
    tick();
    chk("rci_rdData", rdData, 32'h88);
    tick();

    // ---------------- CSRRSI zimm=1 on 0x80 ----------------
    issue(3'b110, 12'h300, 32'h0, 5'd1, 5'd1, 32'h00000080, 1'b1);
    tick();
    instrValid = 1'b0;
    tick();
    chk("rsi_we", csrWriteEnable, 1);
    chk("rsi_wdata", csrWriteData, 32'h81);
    tick();
    chk("rsi_done", done, 1);
    tick();

    // ---------------- CSRRW rd=0: write only ----------------
    issue(3'b001, 12'h340, 32'hCAFEF00D, 5'd9, 5'd0, 32'h11111111, 1'b1);
    tick();
    instrValid = 1'b0;
    chk("rwz_re", csrReadEnable, 0);
    chk("rwz_we", csrWriteEnable, 1);
    chk("rwz_waddr", csrWriteAddress, 32'h340);
    chk("rwz_wdata", csrWriteData, 32'hCAFEF00D);
    tick();
    chk("rwz_done", done, 1);
    chk("rwz_done_re", csrReadEnable, 0);
    chk("rwz_rdWe", rdWriteEnable, 0);
    chk("rwz_rdData", rdData, 0);
    tick();

    // ---------------- unmapped 0x7FF ----------------
    issue(3'b010, 12'h7FF, 32'h0, 5'd2, 5'd4, 32'h0, 1'b0);
    tick();
    instrValid = 1'b0;
    chk("unm_re", csrReadEnable, 1);
    tick();
    chk("unm_done", done, 1);
    chk("unm_illegal", illegal, 1);
    chk("unm_we", csrWriteEnable, 0);
    chk("unm_rdWe", rdWriteEnable, 0);
    tick();
    chk("unm_after_we", csrWriteEnable, 0);

    // ---------------- CSRRS rs1=1 into read-only 0xC00 ----------------
    issue(3'b010, 12'hC00, 32'h1, 5'd1, 5'd6, 32'h00000055, 1'b1);
    tick();
    instrValid = 1'b0;
    tick();
    chk("ro_done", done, 1);
    chk("ro_illegal", illegal, 1);
    chk("ro_we", csrWriteEnable, 0);
    chk("ro_rdWe", rdWriteEnable, 0);
    tick();
    chk("ro_after_we", csrWriteEnable, 0);

    // ---------------- CSRRS rs1=0 of read-only 0xC00 is legal ----------------
    issue(3'b010, 12'hC00, 32'h0, 5'd0, 5'd6, 32'h00000055, 1'b1);
    tick();
    instrValid = 1'b0;
    tick();
    chk("rok_done", done, 1);
    chk("rok_illegal", illegal, 0);
    chk("rok_rdData", rdData, 32'h55);
    chk("rok_rdWe", rdWriteEnable, 1);
    tick();

    // ---------------- funct3 100 ----------------
    issue(3'b100, 12'h340, 32'h0, 5'd1, 5'd2, 32'h0, 1'b1);
    tick();
    instrValid = 1'b0;
    chk("bad_done", done, 1);
    chk("bad_illegal", illegal, 1);
    chk("bad_re", csrReadEnable, 0);
    chk("bad_we", csrWriteEnable, 0);
    chk("bad_busy", busy, 1);
    tick();
    chk("bad_idle", busy, 0);

    // ---------------- reset during READ of an RMW ----------------
    issue(3'b001, 12'h340, 32'hA5A5A5A5, 5'd3, 5'd5, 32'h0BADF00D, 1'b1);
    tick();
    instrValid = 1'b0;
    chk("ab_read_re", csrReadEnable, 1);
    rst = 1'b0;
    #1;
    chk("ab_re", csrReadEnable, 0);
    chk("ab_busy", busy, 0);
    chk("ab_raddr", csrReadAddress, 0);
    tick();
    chk("ab_hold_we", csrWriteEnable, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_post_we", csrWriteEnable, 0);
      chk("ab_post_done", done, 0);
    end

    // ---------------- normal instruction after abort ----------------
    issue(3'b011, 12'h305, 32'h0000000F, 5'd4, 5'd2, 32'h000000FF, 1'b1);
    tick();
    instrValid = 1'b0;
    tick();
    chk("rec_we", csrWriteEnable, 1);
    chk("rec_wdata", csrWriteData, 32'hF0);
    chk("rec_waddr", csrWriteAddress, 32'h305);
    tick();
    chk("rec_done", done, 1);
    chk("rec_rdData", rdData, 32'hFF);
    chk("rec_rdWe", rdWriteEnable, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
`default_nettype wire
